control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//   Parametrised top-level multicycle sequencer for the RV64 core.
//   It runs fetch -> IR load -> dispatch -> execute for NUM_UNITS execution sub-FSMs (ALU, branch/jump, load/store, FP, ...).
//   It adds fetch and execute watchdogs, an illegal-dispatch trap, single-step/halt control and a retired-instruction counter.
//   It sits between the memory interface, the opcode decoder and the per-class sub-FSMs.
// PARAMETERS
//   NUM_UNITS     3    number of execution sub-FSMs (>=1)
//   CNT_W         32   width of retired-instruction counter
//   TIMER_W       8    width of watchdog counter
//   MEM_TIMEOUT   16   max FETCH cycles without memory_done; 0 = disabled; must be < 2**TIMER_W
//   EXEC_TIMEOUT  64   max EXEC cycles without unit done; 0 = disabled; must be < 2**TIMER_W
// PORTS
//   clk          in   1          rising-edge clock
//   reset        in   1          asynchronous, active-high reset
//   start        in   1          leave IDLE and begin fetching
//   single_step  in   1          sampled at retire: 1 -> return to IDLE after this insn
//   halt_req     in   1          sampled at retire: 1 -> return to IDLE after this insn
//   trap_ack     in   1          clears trap, TRAP -> IDLE
//   memory_done  in   1          memory transaction complete
//   unit_req     in   NUM_UNITS  decoded dispatch vector from opdecoder (valid in DISPATCH)
//   unit_done    in   NUM_UNITS  per-unit completion pulses
//   memory_start out  1          request instruction fetch
//   load_ins     out  1          load instruction register
//   unit_start   out  NUM_UNITS  one-hot start to selected sub-FSM
//   busy         out  1          state not IDLE and not TRAP
//   retire       out  1          1-cycle pulse when an instruction completes
//   trap         out  1          1 while in TRAP
//   trap_cause   out  2          01 fetch timeout, 10 exec timeout, 11 illegal dispatch
//   instret      out  CNT_W      retired-instruction count
// BEHAVIOUR
//   States: IDLE, FETCH, LOAD_IR, DISPATCH, EXEC, TRAP. Reset (async) -> IDLE.
//   Reset values: all outputs 0, including instret, trap_cause, the latched grant and the watchdog counter.
//   IDLE: start=1 -> FETCH.
//   FETCH: memory_start=1.
//     - memory_done=1 -> LOAD_IR.
//     - else if MEM_TIMEOUT!=0 and watchdog==MEM_TIMEOUT-1 -> TRAP, cause 01.
//     - done wins over timeout in the same cycle.
//   LOAD_IR: load_ins=1 for exactly 1 cycle -> DISPATCH.
//   DISPATCH: 1 cycle.
//     - unit_req exactly one-hot -> latch grant=unit_req -> EXEC.
//     - zero or multiple bits set -> TRAP, cause 11; instret unchanged.
//   EXEC: unit_start=grant, held every EXEC cycle and 0 in all other states.
//     - unit_done & grant != 0 -> retire=1 that cycle, instret+=1 (wraps modulo 2**CNT_W).
//       Next state is IDLE if single_step|halt_req, else FETCH.
//     - unit_done bits outside grant are ignored.
//     - else if EXEC_TIMEOUT!=0 and watchdog==EXEC_TIMEOUT-1 -> TRAP, cause 10.
//     - done wins over timeout in the same cycle.
//   Watchdog: cleared on every state change; increments each cycle spent in FETCH or EXEC.
//   TRAP: trap=1; trap_cause held; start ignored; trap_ack=1 -> IDLE.
//     trap_cause is cleared when FETCH is next entered.
//   Outputs are decoded from registered state/grant only (Moore).
//   Exception: retire is Mealy on unit_done, because it retires in the cycle done arrives.
//   Total latency per insn: 1 (LOAD_IR) + 1 (DISPATCH) + fetch cycles + exec cycles.
//   Reset mid-instruction aborts without retiring: instret -> 0 and unit_start drops immediately.
// TESTING
//   T1 NUM_UNITS=3: start=1; memory_done at FETCH cycle 2; unit_req=3'b010; unit_done=3'b010 after 4 EXEC cycles
//      -> unit_start=010 for 4 cycles, retire pulse, instret=1, next state FETCH.
//   T2 No memory_done with MEM_TIMEOUT=16 -> TRAP after exactly 16 FETCH cycles, trap_cause=01;
//      trap_ack -> IDLE, busy=0.
//   T3 unit_req=3'b000 and, separately, 3'b101 -> TRAP cause 11, unit_start never asserted, instret unchanged.
//   T4 grant=001, unit_done=100 for 10 cycles then 001 -> no retire until 001; with EXEC_TIMEOUT=8 -> TRAP cause 10 instead.
//   T5 single_step=1: 3 starts -> 3 retires, IDLE between each; CNT_W=4 with 17 retires -> instret=1 (wrap).
//   T6 reset asserted mid-EXEC (async, between clock edges) -> all outputs 0 immediately; after release, state IDLE.

Source files
------------

// File: rtl/control_sequencer_if.sv
// ---------------------------------------------------------------------------
// control_sequencer_if
//   Groups the handshake and status signals of control_sequencer.
//   The sequencer connects through the master modport. The environment
//   (memory interface, opcode decoder, execution sub-FSMs and core
//   control) connects through the slave modport.
//
//   Control inputs to the sequencer:
//     start, single_step, halt_req, trap_ack
//   Memory handshake:
//     memory_start (out), memory_done (in)
//   Decoder / unit handshake:
//     unit_req (in), unit_done (in), unit_start (out)
//   Status outputs:
//     load_ins, busy, retire, trap, trap_cause, instret
//
//   NUM_UNITS and CNT_W must match the parameters of the attached
//   control_sequencer.
// ---------------------------------------------------------------------------
interface control_sequencer_if #(
    parameter int NUM_UNITS = 3,
    parameter int CNT_W     = 32
) ();
    logic                 start;
    logic                 single_step;
    logic                 halt_req;
    logic                 trap_ack;
    logic                 memory_done;
    logic [NUM_UNITS-1:0] unit_req;
    logic [NUM_UNITS-1:0] unit_done;

    logic                 memory_start;
    logic                 load_ins;
    logic [NUM_UNITS-1:0] unit_start;
    logic                 busy;
    logic                 retire;
    logic                 trap;
    logic [1:0]           trap_cause;
    logic [CNT_W-1:0]     instret;

    modport master (
        input  start, single_step, halt_req, trap_ack, memory_done,
               unit_req, unit_done,
        output memory_start, load_ins, unit_start, busy, retire, trap,
               trap_cause, instret
    );

    modport slave (
        output start, single_step, halt_req, trap_ack, memory_done,
               unit_req, unit_done,
        input  memory_start, load_ins, unit_start, busy, retire, trap,
               trap_cause, instret
    );
endinterface

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Top-level multicycle sequencer for the RV64 core. It runs the loop
//   fetch -> IR load -> dispatch -> execute over NUM_UNITS execution
//   sub-FSMs. It also provides:
//     - fetch and execute watchdogs,
//     - an illegal-dispatch trap,
//     - single-step / halt control,
//     - a retired-instruction counter.
//
// Parameters
//   NUM_UNITS     number of execution sub-FSMs (>= 1)
//   CNT_W         width of the retired-instruction counter
//   TIMER_W       width of the watchdog counter
//   MEM_TIMEOUT   max FETCH cycles without memory_done (0 = disabled)
//   EXEC_TIMEOUT  max EXEC cycles without unit done    (0 = disabled)
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    control_sequencer_if.master:
//            inputs  : start, single_step, halt_req, trap_ack,
//                      memory_done, unit_req, unit_done
//            outputs : memory_start, load_ins, unit_start, busy, retire,
//                      trap, trap_cause, instret
//
// Output behaviour
//   All outputs decode registered state/grant, except retire. Retire
//   combines EXEC with unit_done, so an instruction retires in the same
//   cycle its unit reports completion.
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter int NUM_UNITS    = 3,
    parameter int CNT_W        = 32,
    parameter int TIMER_W      = 8,
    parameter int MEM_TIMEOUT  = 16,
    parameter int EXEC_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    control_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_LOAD_IR  = 3'd2;
    localparam logic [2:0] S_DISPATCH = 3'd3;
    localparam logic [2:0] S_EXEC     = 3'd4;
    localparam logic [2:0] S_TRAP     = 3'd5;

    localparam logic [1:0] CAUSE_FETCH_TO = 2'b01;
    localparam logic [1:0] CAUSE_EXEC_TO  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    // Watchdog value seen in the last permitted cycle of each phase.
    localparam logic [TIMER_W-1:0] MEM_LAST  =
        (MEM_TIMEOUT  == 0) ? '0 : TIMER_W'(MEM_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] EXEC_LAST =
        (EXEC_TIMEOUT == 0) ? '0 : TIMER_W'(EXEC_TIMEOUT - 1);

    logic [2:0]           state_q,    state_d;
    logic [NUM_UNITS-1:0] grant_q,    grant_d;
    logic [1:0]           cause_q,    cause_d;
    logic [CNT_W-1:0]     instret_q,  instret_d;
    logic [TIMER_W-1:0]   watchdog_q, watchdog_d;

    logic                 unit_fin;
    logic                 mem_expired;
    logic                 exec_expired;

    // Only completion bits of the granted unit count; other bits are ignored.
    assign unit_fin     = (state_q == S_EXEC) && (|(bus.unit_done & grant_q));
    assign mem_expired  = (MEM_TIMEOUT  != 0) && (watchdog_q == MEM_LAST);
    assign exec_expired = (EXEC_TIMEOUT != 0) && (watchdog_q == EXEC_LAST);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cause_d   = cause_q;
        instret_d = instret_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    cause_d = '0;
                end
            end
            S_FETCH: begin
                // Completion takes priority over an expiring watchdog.
                if (bus.memory_done) begin
                    state_d = S_LOAD_IR;
                end else if (mem_expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_FETCH_TO;
                end
            end
            S_LOAD_IR: begin
                state_d = S_DISPATCH;
            end
            S_DISPATCH: begin
                if ($onehot(bus.unit_req)) begin
                    grant_d = bus.unit_req;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (unit_fin) begin
                    instret_d = instret_q + CNT_W'(1);
                    if (bus.single_step || bus.halt_req) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                        cause_d = '0;
                    end
                end else if (exec_expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_EXEC_TO;
                end
            end
            S_TRAP: begin
                if (bus.trap_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The watchdog restarts on every state change and only runs in the
    // two phases that wait on an external party.
    always_comb begin
        watchdog_d = '0;
        if ((state_d == state_q) &&
            ((state_q == S_FETCH) || (state_q == S_EXEC))) begin
            watchdog_d = watchdog_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            cause_q    <= '0;
            instret_q  <= '0;
            watchdog_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cause_q    <= cause_d;
            instret_q  <= instret_d;
            watchdog_q <= watchdog_d;
        end
    end

    assign bus.memory_start = (state_q == S_FETCH);
    assign bus.load_ins     = (state_q == S_LOAD_IR);
    // grant stays latched after EXEC, so unit_start must be gated by state.
    assign bus.unit_start   = (state_q == S_EXEC) ? grant_q : '0;
    assign bus.busy         = (state_q != S_IDLE) && (state_q != S_TRAP);
    assign bus.retire       = unit_fin;
    assign bus.trap         = (state_q == S_TRAP);
    assign bus.trap_cause   = cause_q;
    assign bus.instret      = instret_q;

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//   Self-checking bench for control_sequencer.
//   DUT configuration: NUM_UNITS=3, CNT_W=4, MEM_TIMEOUT=16, EXEC_TIMEOUT=12.
//   EXEC_TIMEOUT=12 lets the same DUT tolerate ten ignored done pulses and
//   still show the exec watchdog firing. Retire and trap expectations are
//   queued when stimulus is driven; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    logic clk;
    logic reset;

    control_sequencer_if #(.NUM_UNITS(3), .CNT_W(4)) bus ();

    control_sequencer #(
        .NUM_UNITS   (3),
        .CNT_W       (4),
        .TIMER_W     (8),
        .MEM_TIMEOUT (16),
        .EXEC_TIMEOUT(12)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] grant;
        logic [3:0] cnt;
    } ret_t;

    ret_t       ret_q[$];
    logic [1:0] trap_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] exp_cnt = '0;
    logic       trap_prev = 1'b0;
    logic       pend = 1'b0;
    logic [3:0] pend_cnt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Retire / trap scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (pend) begin
                check("instret_after_retire", 32'(bus.instret), 32'(pend_cnt));
                pend = 1'b0;
            end
            if (bus.retire) begin
                if (ret_q.size() == 0) begin
                    check("unexpected_retire", 32'(bus.retire), 32'd0);
                end else begin
                    ret_t e;
                    e = ret_q.pop_front();
                    check("retire_unit_start", 32'(bus.unit_start), 32'(e.grant));
                    pend_cnt = e.cnt;
                    pend     = 1'b1;
                end
            end
            if (bus.trap && !trap_prev) begin
                if (trap_q.size() == 0) begin
                    check("unexpected_trap", 32'(bus.trap), 32'd0);
                end else begin
                    logic [1:0] c;
                    c = trap_q.pop_front();
                    check("trap_cause_sb", 32'(bus.trap_cause), 32'(c));
                end
            end
            trap_prev = bus.trap;
        end else begin
            trap_prev = 1'b0;
        end
    end

    // Drives from IDLE (or from FETCH) up to the DISPATCH state.
    task automatic to_dispatch(input bit from_idle, input int fetch_n);
        if (from_idle) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        for (int i = 1; i <= fetch_n; i++) begin
            if (i == 1) check("fetch_memory_start", 32'(bus.memory_start), 32'd1);
            bus.memory_done = (i == fetch_n);
            tick();
        end
        bus.memory_done = 1'b0;
        check("load_ins", 32'(bus.load_ins), 32'd1);
        tick();
        check("dispatch_load_ins_low", 32'(bus.load_ins), 32'd0);
    endtask

    task automatic exec_insn(input bit from_idle, input int fetch_n, input logic [2:0] req,
                             input int exec_n, input logic [2:0] noise,
                             input bit step, input bit halt);
        to_dispatch(from_idle, fetch_n);
        bus.unit_req = req;
        tick();
        bus.unit_req = '0;
        for (int i = 1; i <= exec_n; i++) begin
            check("exec_unit_start", 32'(bus.unit_start), 32'(req));
            if (i == exec_n) begin
                bus.unit_done   = req;
                bus.single_step = step;
                bus.halt_req    = halt;
                exp_cnt         = exp_cnt + 4'd1;
                ret_q.push_back('{req, exp_cnt});
            end else begin
                bus.unit_done = noise;
            end
            tick();
        end
        bus.unit_done   = '0;
        bus.single_step = 1'b0;
        bus.halt_req    = 1'b0;
        check("post_busy", 32'(bus.busy), 32'(!(step || halt)));
        check("post_unit_start", 32'(bus.unit_start), 32'd0);
    endtask

    task automatic ack_trap();
        bus.trap_ack = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        check("ack_trap_low", 32'(bus.trap), 32'd0);
        check("ack_busy_low", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] bad_req[2];
        bad_req[0] = 3'b000;
        bad_req[1] = 3'b101;

        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.single_step = 1'b0;
        bus.halt_req    = 1'b0;
        bus.trap_ack    = 1'b0;
        bus.memory_done = 1'b0;
        bus.unit_req    = '0;
        bus.unit_done   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_memory_start", 32'(bus.memory_start), 32'd0);
        check("rst_load_ins",     32'(bus.load_ins),     32'd0);
        check("rst_unit_start",   32'(bus.unit_start),   32'd0);
        check("rst_busy",         32'(bus.busy),         32'd0);
        check("rst_trap",         32'(bus.trap),         32'd0);
        check("rst_trap_cause",   32'(bus.trap_cause),   32'd0);
        check("rst_instret",      32'(bus.instret),      32'd0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(bus.busy), 32'd0);

        // T1: fetch 2 cycles, unit 1 for 4 exec cycles, continues to FETCH.
        exec_insn(1'b1, 2, 3'b010, 4, 3'b000, 1'b0, 1'b0);
        check("t1_next_fetch", 32'(bus.memory_start), 32'd1);
        exec_insn(1'b0, 1, 3'b100, 1, 3'b000, 1'b1, 1'b0);

        // T2: fetch watchdog fires after exactly 16 FETCH cycles.
        trap_q.push_back(2'b01);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) check("t2_no_trap_yet", 32'(bus.trap), 32'd0);
            tick();
        end
        check("t2_trap", 32'(bus.trap), 32'd1);
        check("t2_cause", 32'(bus.trap_cause), 32'd1);
        check("t2_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t2_start_ignored", 32'(bus.trap), 32'd1);
        ack_trap();
        check("t2_cause_held", 32'(bus.trap_cause), 32'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t2_cause_cleared", 32'(bus.trap_cause), 32'd0);
        // memory_done in the last permitted cycle wins over the watchdog.
        exec_insn(1'b0, 16, 3'b001, 1, 3'b000, 1'b1, 1'b0);

        // T3: illegal dispatch vectors.
        foreach (bad_req[k]) begin
            trap_q.push_back(2'b11);
            to_dispatch(1'b1, 1);
            bus.unit_req = bad_req[k];
            tick();
            bus.unit_req = '0;
            check("t3_trap", 32'(bus.trap), 32'd1);
            check("t3_cause", 32'(bus.trap_cause), 32'd3);
            check("t3_unit_start", 32'(bus.unit_start), 32'd0);
            check("t3_instret", 32'(bus.instret), 32'(exp_cnt));
            ack_trap();
        end

        // T4: foreign done bits ignored, then exec watchdog.
        exec_insn(1'b1, 1, 3'b001, 11, 3'b100, 1'b1, 1'b0);
        trap_q.push_back(2'b10);
        to_dispatch(1'b1, 1);
        bus.unit_req = 3'b001;
        tick();
        bus.unit_req = '0;
        for (int i = 1; i <= 12; i++) begin
            bus.unit_done = 3'b100;
            if (i == 12) check("t4_no_trap_yet", 32'(bus.trap), 32'd0);
            tick();
        end
        bus.unit_done = '0;
        check("t4_trap", 32'(bus.trap), 32'd1);
        check("t4_cause", 32'(bus.trap_cause), 32'd2);
        check("t4_unit_start", 32'(bus.unit_start), 32'd0);
        ack_trap();
        // Done in the last permitted exec cycle wins; halt_req returns to IDLE.
        exec_insn(1'b1, 1, 3'b001, 12, 3'b100, 1'b0, 1'b1);

        // T6: asynchronous reset in the middle of EXEC.
        to_dispatch(1'b1, 1);
        bus.unit_req = 3'b010;
        tick();
        bus.unit_req = '0;
        tick();
        check("t6_pre_unit_start", 32'(bus.unit_start), 32'd2);
        #3;
        bus.unit_done = 3'b010;
        reset         = 1'b1;
        #1;
        check("t6_unit_start", 32'(bus.unit_start), 32'd0);
        check("t6_busy",       32'(bus.busy),       32'd0);
        check("t6_retire",     32'(bus.retire),     32'd0);
        check("t6_instret",    32'(bus.instret),    32'd0);
        check("t6_trap",       32'(bus.trap),       32'd0);
        exp_cnt = '0;
        bus.unit_done = '0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("t6_idle_busy", 32'(bus.busy), 32'd0);
        check("t6_idle_memory_start", 32'(bus.memory_start), 32'd0);

        // T5: single-step returns to IDLE; 17 retires wrap a 4-bit counter.
        for (int n = 1; n <= 17; n++) begin
            exec_insn(1'b1, 1 + (n % 3), 3'b001 << (n % 3), 1 + (n % 2),
                      3'b000, (n % 2) == 1, (n % 2) == 0);
            if (n <= 3) check("t5_idle_between", 32'(bus.memory_start), 32'd0);
        end
        tick();
        check("t5_instret_wrap", 32'(bus.instret), 32'd1);

        tick();
        check("sb_retire_empty", 32'(ret_q.size()), 32'd0);
        check("sb_trap_empty", 32'(trap_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
